vidbus_mem_target: RTL and testbench

// - Memory-side responder (target) for the video bus issued by the vid5a display controller.
// - Accepts single or burst read/write commands, acknowledges them, and services them from an internal frame-buffer RAM.
// - Returns read data as an RDATA beat stream: fixed latency, no backpressure.
// - Sits between the bus fabric and frame-buffer storage; the display engine is the only initiator.

---
 rtl/vidbus_pkg.sv | 27 ++
 rtl/vidbus_mem_target_if.sv | 26 ++
 rtl/fb_ram.sv | 23 ++
 rtl/vidbus_mem_target.sv | 150 +++++++++++++++
 tb/tb_vidbus_mem_target.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vidbus_pkg.sv
// Shared video-bus definitions: command codes, burst length code and target FSM states.
package vidbus_pkg;

  typedef enum logic [2:0] {
    CMD_IDLE  = 3'b000,
    CMD_RD    = 3'b001,
    CMD_WR    = 3'b010,
    CMD_WDATA = 3'b011,
    CMD_RDATA = 3'b100,
    CMD_ERR   = 3'b111
  } cmd_e;

  typedef logic [1:0] len_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WDATA,
    ST_RWAIT,
    ST_RDATA
  } st_e;

  // Burst code 00/01/10/11 -> 1/2/4/8 words.
  function automatic logic [3:0] burst_beats(len_t len);
    return 4'd1 << len;
  endfunction

endpackage

// File: rtl/vidbus_mem_target_if.sv
// Video-bus signal bundle between the display-controller initiator and the memory target.
interface vidbus_mem_target_if;
  import vidbus_pkg::*;

  // Handshake: the initiator holds selin/cmdin/lenin/addrdatain of an address
  // phase until it sees the one-cycle ackout pulse; WDATA beats need no ack;
  // RDATA beats (cmdout==RDATA) carry no backpressure and must be taken as they come.
  logic        selin;
  logic [2:0]  cmdin;
  len_t        lenin;
  logic [31:0] addrdatain;
  logic        ackout;
  logic [2:0]  cmdout;
  logic [31:0] addrdataout;

  modport master (
    output selin, cmdin, lenin, addrdatain,
    input  ackout, cmdout, addrdataout
  );

  modport slave (
    input  selin, cmdin, lenin, addrdatain,
    output ackout, cmdout, addrdataout
  );

endinterface

// File: rtl/fb_ram.sv
// Single-port frame-buffer RAM with registered read; contents are not reset.
module fb_ram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vidbus_mem_target.sv
// Memory-side video-bus target: accepts single/burst RD/WR, writes WDATA beats to
// the frame buffer and streams read data back at a fixed latency.
module vidbus_mem_target
  import vidbus_pkg::*;
#(
  parameter int AW     = 12,
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  vidbus_mem_target_if.slave   bus,
  output st_e                  dbg_state
);

  st_e           state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    rem_q, rem_d;
  logic [2:0]    lat_q, lat_d;
  logic          rvalid_q, rvalid_d;
  logic          ack_q, ack_d;
  logic [2:0]    cmdout_q, cmdout_d;
  logic [31:0]   dout_q, dout_d;

  logic          ram_we, ram_re, rd_issue;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;
  logic [AW-1:0] bus_word;
  logic [3:0]    nbeats;
  logic          is_rdwr, is_wdata;

  assign bus_word = bus.addrdatain[AW+1:2];
  assign nbeats   = burst_beats(bus.lenin);
  assign is_rdwr  = bus.selin && (bus.cmdin == CMD_RD || bus.cmdin == CMD_WR);
  assign is_wdata = bus.selin && (bus.cmdin == CMD_WDATA);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    lat_d    = lat_q;
    rvalid_d = 1'b0;
    ack_d    = 1'b0;
    cmdout_d = CMD_IDLE;
    dout_d   = dout_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = addr_q;
    rd_issue = 1'b0;

    // RAM output registered last cycle becomes this cycle's RDATA beat.
    if (rvalid_q) begin
      cmdout_d = CMD_RDATA;
      dout_d   = ram_rdata;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (is_rdwr) begin
          ack_d = 1'b1;
          if (bus.cmdin == CMD_WR) begin
            state_d = ST_WDATA;
            addr_d  = bus_word;
            rem_d   = nbeats;
          end else begin
            state_d = ST_RWAIT;
            if (RD_LAT == 1) begin
              // Shortest latency: the first RAM read must go out on the accept edge.
              ram_re   = 1'b1;
              ram_addr = bus_word;
              addr_d   = bus_word + AW'(1);
              rem_d    = nbeats - 4'd1;
              rvalid_d = 1'b1;
              lat_d    = 3'd0;
            end else begin
              addr_d = bus_word;
              rem_d  = nbeats;
              lat_d  = 3'(RD_LAT - 2);
            end
          end
        end
      end
      ST_WDATA: begin
        if (!ack_q && is_rdwr) begin
          cmdout_d = CMD_ERR;
          state_d  = ST_IDLE;
          rem_d    = 4'd0;
        end else if (is_wdata) begin
          ram_we = 1'b1;
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - 4'd1;
          if (rem_q == 4'd1) state_d = ST_IDLE;
        end
      end
      ST_RWAIT: begin
        if (lat_q != 3'd0) lat_d = lat_q - 3'd1;
        else if (rem_q != 4'd0) rd_issue = 1'b1;
        if (rvalid_q) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (rem_q != 4'd0) rd_issue = 1'b1;
        else if (!rvalid_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rd_issue) begin
      ram_re   = 1'b1;
      addr_d   = addr_q + AW'(1);
      rem_d    = rem_q - 4'd1;
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      lat_q    <= '0;
      rvalid_q <= 1'b0;
      ack_q    <= 1'b0;
      cmdout_q <= CMD_IDLE;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      lat_q    <= lat_d;
      rvalid_q <= rvalid_d;
      ack_q    <= ack_d;
      cmdout_q <= cmdout_d;
      dout_q   <= dout_d;
    end
  end

  fb_ram #(.AW(AW)) u_fb_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (bus.addrdatain),
    .rdata (ram_rdata)
  );

  assign bus.ackout      = ack_q;
  assign bus.cmdout      = cmdout_q;
  assign bus.addrdataout = dout_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_vidbus_mem_target.sv
// Self-checking bench for vidbus_mem_target: directed table, corner sequences, random bursts.
module tb_vidbus_mem_target;
  import vidbus_pkg::*;

  localparam int AW     = 12;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  st_e  dbg_state;

  vidbus_mem_target_if bus();

  vidbus_mem_target #(.AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] wr_q [$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  len;
    int          gap_after;
    int          gap_len;
    logic [31:0] d [8];
  } vec_t;

  vec_t vt [9];

  int          rnd_word [$];
  int          rnd_len [$];

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: actual %h required %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int beats(input logic [1:0] len);
    return 1 << len;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(DEPTH));
  endfunction

  task automatic drive(input logic sel, input logic [2:0] cmd, input logic [1:0] len,
                       input logic [31:0] ad);
    bus.selin      = sel;
    bus.cmdin      = cmd;
    bus.lenin      = len;
    bus.addrdatain = ad;
  endtask

  task automatic drive_idle();
    drive(1'b0, 3'b000, 2'b00, 32'h0);
  endtask

  task automatic set_vec(input int i, input bit wr, input logic [31:0] addr,
                         input logic [1:0] len, input int ga, input int gl);
    vt[i].wr        = wr;
    vt[i].addr      = addr;
    vt[i].len       = len;
    vt[i].gap_after = ga;
    vt[i].gap_len   = gl;
    for (int j = 0; j < 8; j++) vt[i].d[j] = 32'h0;
  endtask

  // Write burst; data taken from wr_q, reference memory updated per beat.
  task automatic run_write(input logic [31:0] addr, input logic [1:0] len,
                           input int gap_after, input int gap_len, input bit hold_ack);
    int n;
    int w;
    logic [31:0] d;
    n = beats(len);
    w = word_of(addr);
    drive(1'b1, CMD_WR, len, addr);
    tick();
    chk("wr_ack", 32'(bus.ackout), 32'd1);
    if (hold_ack) begin
      tick();
      chk("wr_ackcycle_no_ack", 32'(bus.ackout), 32'd0);
      chk("wr_ackcycle_no_err", 32'(bus.cmdout), 32'(CMD_IDLE));
    end
    for (int i = 0; i < n; i++) begin
      d = wr_q.pop_front();
      drive(1'b1, CMD_WDATA, 2'($urandom_range(0, 3)), d);
      tick();
      ref_mem[(w + i) % DEPTH] = d;
      chk("wr_cmdout", 32'(bus.cmdout), 32'(CMD_IDLE));
      chk("wr_noack", 32'(bus.ackout), 32'd0);
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          if ($urandom_range(0, 1) == 1) drive(1'b1, CMD_IDLE, 2'b00, $urandom);
          else drive(1'b0, 3'($urandom_range(0, 7)), 2'b00, $urandom);
          tick();
        end
      end
    end
    drive_idle();
  endtask

  // Read burst; expects ack in cycle 1, beats in cycles RD_LAT+1..RD_LAT+N from exp_q.
  task automatic run_read(input logic [31:0] addr, input logic [1:0] len,
                          input bit hold, input bit noise);
    int n;
    n = beats(len);
    drive(1'b1, CMD_RD, len, addr);
    tick();
    for (int k = 1; k <= RD_LAT + n + 1; k++) begin
      if (k > 1) tick();
      chk("rd_ack", 32'(bus.ackout), 32'(k == 1));
      if (k > RD_LAT && k <= RD_LAT + n) begin
        chk("rd_cmd_rdata", 32'(bus.cmdout), 32'(CMD_RDATA));
        if (exp_q.size() > 0) chk("rd_data", bus.addrdataout, exp_q.pop_front());
      end else begin
        chk("rd_cmd_idle", 32'(bus.cmdout), 32'(CMD_IDLE));
      end
      if (!hold) begin
        if (noise && k <= RD_LAT + n)
          drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)), $urandom);
        else
          drive_idle();
      end
    end
  endtask

  task automatic push_ref(input logic [31:0] addr, input logic [1:0] len);
    int w;
    w = word_of(addr);
    for (int i = 0; i < beats(len); i++) exp_q.push_back(ref_mem[(w + i) % DEPTH]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    int          idx;
    logic [1:0]  l;
    logic [1:0]  lr;

    // ---------------- clock / reset ----------------
    reset = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(bus.ackout), 32'd0);
    chk("rst_cmd", 32'(bus.cmdout), 32'(CMD_IDLE));
    chk("rst_data", bus.addrdataout, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;
    tick();

    // ---------------- directed table ----------------
    set_vec(0, 1, 32'h0000_0010, 2'b00, -1, 0); vt[0].d[0] = 32'hDEAD_BEEF;
    set_vec(1, 0, 32'h0000_0010, 2'b00, -1, 0); vt[1].d[0] = 32'hDEAD_BEEF;
    set_vec(2, 1, 32'h0000_0040, 2'b11,  2, 2);
    set_vec(3, 0, 32'h0000_0040, 2'b11, -1, 0);
    for (int j = 0; j < 8; j++) begin
      vt[2].d[j] = 32'h100 + 32'(j);
      vt[3].d[j] = 32'h100 + 32'(j);
    end
    set_vec(4, 1, 32'h0000_3FF8, 2'b10, -1, 0);
    vt[4].d[0] = 32'hA0A0_A0A0; vt[4].d[1] = 32'hB0B0_B0B0;
    vt[4].d[2] = 32'hC0C0_C0C0; vt[4].d[3] = 32'hD0D0_D0D0;
    set_vec(5, 0, 32'h0000_0000, 2'b01, -1, 0);
    vt[5].d[0] = 32'hC0C0_C0C0; vt[5].d[1] = 32'hD0D0_D0D0;
    set_vec(6, 0, 32'h0000_3FF8, 2'b00, -1, 0); vt[6].d[0] = 32'hA0A0_A0A0;
    set_vec(7, 0, 32'h0000_4012, 2'b00, -1, 0); vt[7].d[0] = 32'hDEAD_BEEF;
    set_vec(8, 0, 32'h0000_3FFC, 2'b01, -1, 0);
    vt[8].d[0] = 32'hB0B0_B0B0; vt[8].d[1] = 32'hC0C0_C0C0;

    for (int i = 0; i < 9; i++) begin
      if (vt[i].wr) begin
        for (int j = 0; j < beats(vt[i].len); j++) wr_q.push_back(vt[i].d[j]);
        run_write(vt[i].addr, vt[i].len, vt[i].gap_after, vt[i].gap_len, 1'b0);
      end else begin
        for (int j = 0; j < beats(vt[i].len); j++) exp_q.push_back(vt[i].d[j]);
        run_read(vt[i].addr, vt[i].len, 1'b0, 1'b1);
      end
    end

    // ---------------- illegal / WDATA codes in IDLE ----------------
    drive(1'b1, 3'b101, 2'b11, 32'h10);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("illegal_ack", 32'(bus.ackout), 32'd0);
      chk("illegal_cmd", 32'(bus.cmdout), 32'(CMD_IDLE));
    end
    drive(1'b1, CMD_WDATA, 2'b00, 32'h1234_5678);
    tick();
    chk("wdata_idle_ack", 32'(bus.ackout), 32'd0);
    chk("wdata_idle_state", 32'(dbg_state), 32'(ST_IDLE));
    drive_idle();
    tick();

    // ---------------- write abort, then reissued RD ----------------
    drive(1'b1, CMD_WR, 2'b11, 32'h0000_0200);
    tick();
    chk("abort_wr_ack", 32'(bus.ackout), 32'd1);
    tick();
    chk("abort_ackcycle_no_err", 32'(bus.cmdout), 32'(CMD_IDLE));
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, CMD_WDATA, 2'b00, 32'h1111_0000 * 32'(i + 1));
      ref_mem[word_of(32'h200) + i] = 32'h1111_0000 * 32'(i + 1);
      tick();
    end
    drive(1'b1, CMD_RD, 2'b00, 32'h0000_0040);
    tick();
    chk("abort_err", 32'(bus.cmdout), 32'(CMD_ERR));
    chk("abort_no_ack", 32'(bus.ackout), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    push_ref(32'h40, 2'b00);
    run_read(32'h0000_0040, 2'b00, 1'b0, 1'b0);
    exp_q.push_back(32'h1111_0000);
    exp_q.push_back(32'h2222_0000);
    run_read(32'h0000_0200, 2'b01, 1'b0, 1'b0);

    // ---------------- RD held through an active burst ----------------
    push_ref(32'h40, 2'b11);
    run_read(32'h0000_0040, 2'b11, 1'b1, 1'b0);
    push_ref(32'h40, 2'b11);
    run_read(32'h0000_0040, 2'b11, 1'b0, 1'b0);

    // ---------------- reset during beat 2 of an 8-word read ----------------
    drive(1'b1, CMD_RD, 2'b11, 32'h0000_0040);
    tick();
    drive_idle();
    for (int k = 2; k <= RD_LAT + 2; k++) tick();
    chk("rst_mid_beat2_cmd", 32'(bus.cmdout), 32'(CMD_RDATA));
    chk("rst_mid_beat2_data", bus.addrdataout, 32'h101);
    #2;
    reset = 1'b0;
    tick();
    chk("rst_mid_cmd", 32'(bus.cmdout), 32'(CMD_IDLE));
    chk("rst_mid_ack", 32'(bus.ackout), 32'd0);
    chk("rst_mid_data", bus.addrdataout, 32'h0);
    chk("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;
    tick();
    for (int j = 0; j < 8; j++) exp_q.push_back(32'h100 + 32'(j));
    run_read(32'h0000_0040, 2'b11, 1'b0, 1'b0);

    // ---------------- random bursts against the reference memory ----------------
    for (int t = 0; t < 40; t++) begin
      ra = $urandom;
      l  = 2'($urandom_range(0, 3));
      for (int j = 0; j < beats(l); j++) wr_q.push_back($urandom);
      run_write(ra, l, $urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      rnd_word.push_back(word_of(ra));
      rnd_len.push_back(int'(l));
      idx = $urandom_range(0, rnd_word.size() - 1);
      lr  = 2'($urandom_range(0, rnd_len[idx]));
      ra  = ($urandom & 32'hFFFF_C000) | (32'(rnd_word[idx]) << 2) | 32'($urandom_range(0, 3));
      push_ref(ra, lr);
      run_read(ra, lr, 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
